inst_fetch_queue: RTL
=====================

Name: inst_fetch_queue

Overview:
Decoupling instruction queue between the IF stage (PC/ROM) and the ID stage. Each cycle it captures the (pc, instruction) pair returned by the synchronous instruction ROM, buffers up to DEPTH entries, and presents them in order to decode. When it fills, it back-pressures fetch by asserting the PC stall. Exception flushes discard all buffered entries.

Parameters:
DEPTH, 4, number of entries; power of two, at least 2
ADDR_WIDTH, 32, PC width
DATA_WIDTH, 32, instruction width
CNT_WIDTH, 3, occupancy counter width; must equal clog2(DEPTH)+1

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  exception/redirect flush; discards all entries
fetch_valid  input  1  fetch_pc/fetch_inst hold a valid ROM result this cycle (driven by rom_en)
fetch_pc  input  ADDR_WIDTH  PC of the instruction on fetch_inst
fetch_inst  input  DATA_WIDTH  ROM read data for fetch_pc
stall_pc  output  1  hold PC and ROM address; the same pair is re-presented next cycle
id_ready  input  1  ID consumes the head entry this cycle
id_valid  output  1  head entry valid
id_pc  output  ADDR_WIDTH  head entry PC
id_inst  output  DATA_WIDTH  head entry instruction
id_exc_adel  output  1  head entry has a misaligned fetch address
count  output  CNT_WIDTH  current occupancy, 0..DEPTH

Behaviour:
- Reset (synchronous, active-high): rd_ptr=0, wr_ptr=0, count=0. id_valid=0, id_pc=0, id_inst=0, id_exc_adel=0, stall_pc=0. Storage contents are don't-care.
- Storage: circular array of {pc, inst, adel}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- full = (count==DEPTH). empty = (count==0).
- deq = id_valid & id_ready & !flush.
- enq = fetch_valid & !flush & (!full | deq). A full queue accepts a new entry in the same cycle the head is consumed.
- stall_pc = !flush & full & !deq. This is combinational and independent of fetch_valid. While it is asserted, PC holds, the same pair reappears next cycle, and it is not enqueued until space exists. No duplicate entry is ever written.
- Enqueue entry: pc=fetch_pc, adel=(fetch_pc[1:0]!=0). inst=fetch_inst when adel=0, and inst=0 when adel=1.
- Outputs are combinational from the entry at rd_ptr. When empty, id_valid=0 and id_pc, id_inst and id_exc_adel are all 0. There is no bypass: an entry written at edge t is first visible after edge t, so minimum latency is 1 cycle.
- Count update: enq&!deq gives +1, deq&!enq gives -1, otherwise unchanged. Simultaneous enq and deq when empty is impossible because deq requires id_valid.
- Flush takes priority over everything. On the flush edge, rd_ptr, wr_ptr and count are set to 0. The pair presented during the flush cycle is dropped, and no dequeue is counted. From the next cycle on, normal operation resumes; the first pair after flush is the redirect target returned by the ROM.
- flush and rst asserted together: the result is identical to reset.
- fetch_valid=0: no enqueue; stall_pc still follows the rule above.
- Branch redirection enters this block only as flush. No delay-slot bookkeeping happens here.

Test Plan:
- Reset, then fetch_valid=1 with pc 0xBFC00000, 0xBFC00004, and so on, id_ready=1 -> id_valid rises 1 cycle after the first enqueue; id_pc follows the sequence in order; count stays at 1; stall_pc stays 0.
- id_ready=0, 5 consecutive pairs offered (DEPTH=4) -> count goes 1,2,3,4; stall_pc=1 while the 5th pair (0x...10) is held for 3 cycles; no entry is written; the head stays 0xBFC00000.
- Full queue with the 5th pair held, then id_ready=1 for one cycle -> stall_pc=0 that cycle; the head is consumed and 0x...10 is enqueued in the same edge; count stays 4; the new head is 0x...04.
- Queue holding 3 entries, flush=1 while fetch_valid=1 with pc 0x...20 -> next cycle count=0 and id_valid=0; 0x...20 is never output; the next pair 0xBFC00380 becomes the head 1 cycle later.
- fetch_pc=0xBFC00002, fetch_inst=0x24020001 -> the entry is output with id_exc_adel=1, id_inst=0, id_pc=0xBFC00002.
- Run 10+ enqueue/dequeue cycles with random id_ready -> pointers wrap past DEPTH-1; output order is preserved with no loss or duplication; count always equals enqueued minus dequeued.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Handshake bundle between fetch (PC/ROM) and decode around inst_fetch_queue.
interface inst_fetch_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [DATA_WIDTH-1:0] fetch_inst;
  logic                  stall_pc;
  logic                  id_ready;
  logic                  id_valid;
  logic [ADDR_WIDTH-1:0] id_pc;
  logic [DATA_WIDTH-1:0] id_inst;
  logic                  id_exc_adel;

  modport master (
    output fetch_valid, fetch_pc, fetch_inst, id_ready,
    input  stall_pc, id_valid, id_pc, id_inst, id_exc_adel
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst, id_ready,
    output stall_pc, id_valid, id_pc, id_inst, id_exc_adel
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode; stalls the PC when full
// and discards all buffered entries on an exception/redirect flush.
module inst_fetch_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  inst_fetch_queue_if.slave    bus,
  output logic [CNT_WIDTH-1:0] count
);
  localparam int PTR_WIDTH = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  adel;
  } entry_t;

  entry_t               mem_q [DEPTH];
  entry_t               mem_d [DEPTH];
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 full_s, empty_s, deq_s, enq_s;
  entry_t               new_entry_s, head_s;

  // Handshake decode; a full queue still accepts when the head leaves this cycle.
  always_comb begin
    full_s       = (count_q == CNT_WIDTH'(DEPTH));
    empty_s      = (count_q == {CNT_WIDTH{1'b0}});
    deq_s        = !empty_s & bus.id_ready & !flush;
    enq_s        = bus.fetch_valid & !flush & (!full_s | deq_s);
    bus.stall_pc = !flush & full_s & !deq_s;
  end

  // Misaligned fetches carry a zeroed instruction so decode never sees stale ROM data.
  always_comb begin
    new_entry_s.pc   = bus.fetch_pc;
    new_entry_s.adel = (bus.fetch_pc[1:0] != 2'b00);
    if (new_entry_s.adel) begin
      new_entry_s.inst = {DATA_WIDTH{1'b0}};
    end else begin
      new_entry_s.inst = bus.fetch_inst;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = {PTR_WIDTH{1'b0}};
      wr_ptr_d = {PTR_WIDTH{1'b0}};
      count_d  = {CNT_WIDTH{1'b0}};
    end else begin
      if (enq_s) begin
        mem_d[wr_ptr_q] = new_entry_s;
        wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= {PTR_WIDTH{1'b0}};
      wr_ptr_q <= {PTR_WIDTH{1'b0}};
      count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is left unreset; empty_s masks whatever it holds.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head_s = mem_q[rd_ptr_q];
    if (empty_s) begin
      bus.id_valid    = 1'b0;
      bus.id_pc       = {ADDR_WIDTH{1'b0}};
      bus.id_inst     = {DATA_WIDTH{1'b0}};
      bus.id_exc_adel = 1'b0;
    end else begin
      bus.id_valid    = 1'b1;
      bus.id_pc       = head_s.pc;
      bus.id_inst     = head_s.inst;
      bus.id_exc_adel = head_s.adel;
    end
  end

  assign count = count_q;
endmodule
